pic_priority_arbiter: RTL and testbench
=======================================

Name: pic_priority_arbiter

Overview:
- Priority resolver and interrupt-acknowledge sequencer for the 8259 PIC core.
- Owns the IRR, IMR and ISR registers and decides which IR line wins.
- Raises the interrupt request and, over the two-pulse INTA sequence (or a poll read), commits the winner to ISR and emits its vector.
- Sits between the bus/control decoder (ICW/OCW strobes, INTA pulses) and the external INT/data path.

Parameters:
- NUM_IR, 8, number of IR lines; power of two, 2..8. IDX_W = clog2(NUM_IR).
- SPURIOUS_IDX, NUM_IR-1, index reported when a request vanishes before the first ack.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- ir_in  input  NUM_IR  raw interrupt request lines
- level_trig  input  1  1 = level-triggered, 0 = edge-triggered (from ICW1)
- init_clear  input  1  one-cycle pulse on ICW1 write
- vector_base  input  8-IDX_W  upper vector bits (from ICW2)
- auto_eoi  input  1  AEOI mode (from ICW4)
- imr_wr  input  1  OCW1 write strobe
- imr_data  input  NUM_IR  new mask
- ocw2_wr  input  1  OCW2 write strobe
- ocw2_data  input  8  [7:5] = R/SL/EOI, [2:0] = level
- ack_pulse  input  1  one-cycle pulse per INTA
- poll_rd  input  1  one-cycle poll read (after OCW3 poll)
- int_req  output  1  registered interrupt request
- vector_out  output  8  vector or poll word
- vector_valid  output  1  one-cycle qualifier for vector_out
- irr, isr, imr  output  NUM_IR each  register views for status reads

Behaviour:
- Reset (reset_n = 0 at a clk edge) and init_clear are identical and have the highest precedence:
  - irr, isr, imr = 0; lowest_prio = NUM_IR-1; rot_aeoi = 0; state = IDLE.
  - int_req = 0; vector_out = 0; vector_valid = 0; edge-history register = all ones.
- IRR update:
  - Level mode: irr <= ir_in.
  - Edge mode: a bit sets on a rising edge (ir_in & ~prev) and clears when ir_in is low. A pending bit stays set while ir_in is held high.
- Resolution (combinational on registered state):
  - req = irr & ~imr.
  - Rotate req and isr right by (lowest_prio+1) mod NUM_IR; the lowest set bit is the highest priority.
  - A winner exists if its rotated position is strictly below the highest in-service rotated position (or isr == 0).
- FSM states: IDLE, PEND, ACK1.
  - IDLE: if a winner exists, int_req <= 1 and go to PEND.
  - PEND, winner disappeared before ack: int_req <= 0 and go to IDLE.
  - PEND, ack_pulse: int_req <= 0 and go to ACK1.
    - With a winner: latch win_idx, set isr[win_idx], clear irr[win_idx] in edge mode.
    - With no winner: latch SPURIOUS_IDX and set no ISR bit.
  - ACK1, ack_pulse (next cycle or later): vector_out <= {vector_base, win_idx}, vector_valid = 1 for one cycle, go to IDLE.
    - If auto_eoi, clear isr[win_idx] in the same cycle; if rot_aeoi is also set, lowest_prio <= win_idx.
- Poll: poll_rd in any state except ACK1 returns one of:
  - {1, 0..0, win_idx}: commit to ISR as in the first ack.
  - 8'h00 if there is no winner.
  - Either way vector_valid pulses, int_req drops, and the FSM returns to IDLE.
- OCW2 (ocw2_data[7:5]):
  - 001: non-specific EOI, clears the highest-priority ISR bit.
  - 011: specific EOI on level.
  - 101: non-specific EOI plus rotate (lowest_prio <= the cleared index).
  - 111: specific EOI plus rotate.
  - 110: set lowest_prio <= level.
  - 100: rot_aeoi <= 1.
  - 000: rot_aeoi <= 0.
  - 010: no-op.
  - Non-specific EOI with isr == 0 has no effect.
- Simultaneous events:
  - An EOI uses the pre-cycle isr.
  - An ISR set in the same cycle wins for the same bit.
  - imr_wr takes effect on resolution from the next cycle.
- Latency: an IR edge produces int_req 2 cycles later (edge register, then IRR, then registered int_req).

Optional Feature:
- PIC_SPECIAL_MASK_EN
- Defined: adds input smm (OCW3 special mask mode). When smm = 1, ISR bits that are masked in imr are excluded from the in-service comparison, so lower levels can interrupt.
- Undefined: the smm port is absent and the comparison uses the full ISR.

Decomposition:
- Package pic_pkg holds:
  - the FSM state enum;
  - OCW2 command codes;
  - a NUM_IR default.
- One sub-module, pic_priority_select, contains the rotate, find-first and rotate-back logic for a given lowest_prio. It is instantiated twice: once for req, once for isr (highest-in-service for non-specific EOI).

Test Plan:
- Edge mode, base = 5'h08, ir_in[3] rises, two ack_pulses -> int_req after 2 cycles; isr = 8'h08; vector_out = 8'h43; irr[3] = 0.
- IR2 in service, IR5 raised -> no int_req. Non-specific EOI (ocw2 = 8'h20) -> isr = 0, then int_req for IR5.
- ocw2 = 8'hC4 (lowest = 4), IR1 and IR5 pending -> IR5 wins, vector low bits = 5.
- ir_in[6] pulses high then low before the first ack -> vector low bits = 7 and isr stays 0.
- auto_eoi = 1 with rot_aeoi set by 8'h80, IR0 acked -> isr stays 0 after the second ack; lowest_prio = 0; IR1 now highest.
- init_clear pulse in ACK1 with isr = 8'h10 -> next cycle isr = imr = 0, int_req = 0, state IDLE; the second ack produces no vector_valid.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 PIC priority arbiter.
package pic_pkg;

  localparam int unsigned PIC_NUM_IR = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StAck1
  } pic_state_e;

  typedef enum logic [2:0] {
    Ocw2RotAeoiClr = 3'b000,
    Ocw2NsEoi      = 3'b001,
    Ocw2Nop        = 3'b010,
    Ocw2SpEoi      = 3'b011,
    Ocw2RotAeoiSet = 3'b100,
    Ocw2RotNsEoi   = 3'b101,
    Ocw2SetPrio    = 3'b110,
    Ocw2RotSpEoi   = 3'b111
  } ocw2_cmd_e;

endpackage

// File: rtl/pic_priority_select.sv
// Rotating priority finder: rotate by lowest+1, pick the lowest set bit, map back to an IR index.
module pic_priority_select #(
  parameter int unsigned NUM_IR = 8
) (
  input  logic [NUM_IR-1:0]         i_vec,
  input  logic [$clog2(NUM_IR)-1:0] i_lowest,
  output logic                      o_found,
  output logic [$clog2(NUM_IR)-1:0] o_idx,
  output logic [$clog2(NUM_IR)-1:0] o_pos
);

  localparam int unsigned IDX_W = $clog2(NUM_IR);

  logic [IDX_W-1:0] w_start;

  // NUM_IR is a power of two, so index arithmetic wraps for free.
  assign w_start = i_lowest + IDX_W'(1);

  always_comb begin
    o_found = 1'b0;
    o_pos   = '0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      if (i_vec[w_start + IDX_W'(k)]) begin
        o_found = 1'b1;
        o_pos   = IDX_W'(k);
      end
    end
    o_idx = o_pos + w_start;
  end

endmodule

// File: rtl/pic_priority_arbiter.sv
// 8259 priority resolver and INTA sequencer owning IRR/IMR/ISR.
// Optional special mask mode input smm is enabled by defining PIC_SPECIAL_MASK_EN.
module pic_priority_arbiter
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR       = PIC_NUM_IR,
  parameter int unsigned SPURIOUS_IDX = NUM_IR - 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_IR-1:0]           ir_in,
  input  logic                        level_trig,
  input  logic                        init_clear,
  input  logic [7-$clog2(NUM_IR):0]   vector_base,
  input  logic                        auto_eoi,
  input  logic                        imr_wr,
  input  logic [NUM_IR-1:0]           imr_data,
  input  logic                        ocw2_wr,
  input  logic [7:0]                  ocw2_data,
  input  logic                        ack_pulse,
  input  logic                        poll_rd,
`ifdef PIC_SPECIAL_MASK_EN
  input  logic                        smm,
`endif
  output logic                        int_req,
  output logic [7:0]                  vector_out,
  output logic                        vector_valid,
  output logic [NUM_IR-1:0]           irr,
  output logic [NUM_IR-1:0]           isr,
  output logic [NUM_IR-1:0]           imr
);

  localparam int unsigned IDX_W = $clog2(NUM_IR);

  pic_state_e       r_state, w_state_d;
  logic [NUM_IR-1:0] r_irr, r_isr, r_imr, r_ir_prev;
  logic [NUM_IR-1:0] w_irr_d, w_isr_d, w_imr_d;
  logic [IDX_W-1:0] r_lowest, w_lowest_d;
  logic [IDX_W-1:0] r_win_idx, w_win_idx_d;
  logic             r_rot_aeoi, w_rot_aeoi_d;
  logic             r_spurious, w_spurious_d;
  logic             r_int_req, w_int_req_d;
  logic [7:0]       r_vector, w_vector_d;
  logic             r_vector_valid, w_vector_valid_d;

  logic [NUM_IR-1:0] w_req, w_isr_cmp;
  logic             w_req_found, w_isr_found, w_winner;
  logic [IDX_W-1:0] w_win_idx, w_req_pos, w_isr_idx, w_isr_pos;
  logic             w_poll, w_commit, w_aeoi_clr;
  logic [7:0]       w_poll_word;
  logic [IDX_W-1:0] w_ocw2_lvl;
  ocw2_cmd_e        w_ocw2_cmd;
  logic             w_unused;

  assign w_req = r_irr & ~r_imr;
`ifdef PIC_SPECIAL_MASK_EN
  assign w_isr_cmp = smm ? (r_isr & ~r_imr) : r_isr;
`else
  assign w_isr_cmp = r_isr;
`endif

  pic_priority_select #(
    .NUM_IR (NUM_IR)
  ) u_req_sel (
    .i_vec    (w_req),
    .i_lowest (r_lowest),
    .o_found  (w_req_found),
    .o_idx    (w_win_idx),
    .o_pos    (w_req_pos)
  );

  pic_priority_select #(
    .NUM_IR (NUM_IR)
  ) u_isr_sel (
    .i_vec    (w_isr_cmp),
    .i_lowest (r_lowest),
    .o_found  (w_isr_found),
    .o_idx    (w_isr_idx),
    .o_pos    (w_isr_pos)
  );

  assign w_winner   = w_req_found && (!w_isr_found || (w_req_pos < w_isr_pos));
  assign w_poll     = poll_rd && (r_state != StAck1);
  assign w_ocw2_lvl = ocw2_data[IDX_W-1:0];
  assign w_ocw2_cmd = ocw2_cmd_e'(ocw2_data[7:5]);
  assign w_unused   = ^ocw2_data[4:3];

  always_comb begin
    w_poll_word = '0;
    if (w_winner) begin
      w_poll_word[7]         = 1'b1;
      w_poll_word[IDX_W-1:0] = w_win_idx;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n || init_clear) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; an ack in PEND wins over a vanished request (spurious path).
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (!w_poll && w_winner) w_state_d = StPend;
      StPend: begin
        if (w_poll)          w_state_d = StIdle;
        else if (ack_pulse)  w_state_d = StAck1;
        else if (!w_winner)  w_state_d = StIdle;
      end
      StAck1: if (ack_pulse) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output and acknowledge-commit logic.
  always_comb begin
    w_int_req_d      = r_int_req;
    w_vector_d       = r_vector;
    w_vector_valid_d = 1'b0;
    w_win_idx_d      = r_win_idx;
    w_spurious_d     = r_spurious;
    w_commit         = 1'b0;
    w_aeoi_clr       = 1'b0;
    unique case (r_state)
      StIdle: w_int_req_d = w_winner && !w_poll;
      StPend: begin
        if (w_poll || ack_pulse || !w_winner) w_int_req_d = 1'b0;
        if (!w_poll && ack_pulse) begin
          w_win_idx_d  = w_winner ? w_win_idx : IDX_W'(SPURIOUS_IDX);
          w_spurious_d = !w_winner;
          w_commit     = w_winner;
        end
      end
      StAck1: begin
        w_int_req_d = 1'b0;
        if (ack_pulse) begin
          w_vector_d       = {vector_base, r_win_idx};
          w_vector_valid_d = 1'b1;
          w_aeoi_clr       = auto_eoi && !r_spurious;
        end
      end
      default: w_int_req_d = 1'b0;
    endcase
    if (w_poll) begin
      w_int_req_d      = 1'b0;
      w_vector_d       = w_poll_word;
      w_vector_valid_d = 1'b1;
      w_commit         = w_winner;
    end
  end

  // IRR/ISR/IMR and priority bookkeeping; ISR set is applied last so it wins.
  always_comb begin
    w_irr_d      = level_trig ? ir_in : ((r_irr | (ir_in & ~r_ir_prev)) & ir_in);
    w_isr_d      = r_isr;
    w_imr_d      = imr_wr ? imr_data : r_imr;
    w_lowest_d   = r_lowest;
    w_rot_aeoi_d = r_rot_aeoi;
    if (ocw2_wr) begin
      unique case (w_ocw2_cmd)
        Ocw2NsEoi: if (w_isr_found) w_isr_d[w_isr_idx] = 1'b0;
        Ocw2RotNsEoi: begin
          if (w_isr_found) begin
            w_isr_d[w_isr_idx] = 1'b0;
            w_lowest_d         = w_isr_idx;
          end
        end
        Ocw2SpEoi: w_isr_d[w_ocw2_lvl] = 1'b0;
        Ocw2RotSpEoi: begin
          w_isr_d[w_ocw2_lvl] = 1'b0;
          w_lowest_d          = w_ocw2_lvl;
        end
        Ocw2SetPrio:    w_lowest_d   = w_ocw2_lvl;
        Ocw2RotAeoiSet: w_rot_aeoi_d = 1'b1;
        Ocw2RotAeoiClr: w_rot_aeoi_d = 1'b0;
        Ocw2Nop: ;
      endcase
    end
    if (w_aeoi_clr) begin
      w_isr_d[r_win_idx] = 1'b0;
      if (r_rot_aeoi) w_lowest_d = r_win_idx;
    end
    if (w_commit) begin
      w_isr_d[w_win_idx] = 1'b1;
      if (!level_trig) w_irr_d[w_win_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || init_clear) begin
      r_irr          <= '0;
      r_isr          <= '0;
      r_imr          <= '0;
      r_ir_prev      <= '1;
      r_lowest       <= IDX_W'(NUM_IR - 1);
      r_rot_aeoi     <= 1'b0;
      r_win_idx      <= '0;
      r_spurious     <= 1'b0;
      r_int_req      <= 1'b0;
      r_vector       <= '0;
      r_vector_valid <= 1'b0;
    end else begin
      r_irr          <= w_irr_d;
      r_isr          <= w_isr_d;
      r_imr          <= w_imr_d;
      r_ir_prev      <= ir_in;
      r_lowest       <= w_lowest_d;
      r_rot_aeoi     <= w_rot_aeoi_d;
      r_win_idx      <= w_win_idx_d;
      r_spurious     <= w_spurious_d;
      r_int_req      <= w_int_req_d;
      r_vector       <= w_vector_d;
      r_vector_valid <= w_vector_valid_d;
    end
  end

  assign int_req      = r_int_req;
  assign vector_out   = r_vector;
  assign vector_valid = r_vector_valid;
  assign irr          = r_irr;
  assign isr          = r_isr;
  assign imr          = r_imr;

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// Directed bench for pic_priority_arbiter; vectors are checked by a queue-based scoreboard.
module tb_pic_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ir_in;
  logic       level_trig, init_clear, auto_eoi, imr_wr, ocw2_wr, ack_pulse, poll_rd;
  logic [4:0] vector_base;
  logic [7:0] imr_data, ocw2_data;
  logic       int_req, vector_valid;
  logic [7:0] vector_out, irr, isr, imr;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pic_priority_arbiter #(
    .NUM_IR       (8),
    .SPURIOUS_IDX (7)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .level_trig   (level_trig),
    .init_clear   (init_clear),
    .vector_base  (vector_base),
    .auto_eoi     (auto_eoi),
    .imr_wr       (imr_wr),
    .imr_data     (imr_data),
    .ocw2_wr      (ocw2_wr),
    .ocw2_data    (ocw2_data),
    .ack_pulse    (ack_pulse),
    .poll_rd      (poll_rd),
`ifdef PIC_SPECIAL_MASK_EN
    .smm          (1'b0),
`endif
    .int_req      (int_req),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .irr          (irr),
    .isr          (isr),
    .imr          (imr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack_pulse = 1'b1;
    @(negedge clk);
    ack_pulse = 1'b0;
  endtask

  task automatic pulse_poll();
    poll_rd = 1'b1;
    @(negedge clk);
    poll_rd = 1'b0;
  endtask

  task automatic write_ocw2(input logic [7:0] d);
    ocw2_wr   = 1'b1;
    ocw2_data = d;
    @(negedge clk);
    ocw2_wr = 1'b0;
  endtask

  task automatic write_imr(input logic [7:0] d);
    imr_wr   = 1'b1;
    imr_data = d;
    @(negedge clk);
    imr_wr = 1'b0;
  endtask

  task automatic wait_int(input string name);
    int n = 0;
    while (int_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(name, int_req, 1'b1);
  endtask

  task automatic full_ack(input logic [7:0] exp_vec);
    pulse_ack();
    exp_q.push_back(exp_vec);
    pulse_ack();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (vector_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=%0h expected=none", vector_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (vector_out !== e) begin
          failures++;
          $display("FAIL sb_vector actual=%0h expected=%0h", vector_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ir_in = '0; level_trig = 1'b0; init_clear = 1'b0; auto_eoi = 1'b0;
    imr_wr = 1'b0; imr_data = '0; ocw2_wr = 1'b0; ocw2_data = '0; ack_pulse = 1'b0;
    poll_rd = 1'b0; vector_base = 5'h08;
    step(2);
    chk("rst_int_req", int_req, 0);
    chk("rst_irr", irr, 0);
    chk("rst_isr", isr, 0);
    chk("rst_imr", imr, 0);
    chk("rst_vector", vector_out, 0);
    chk("rst_valid", vector_valid, 0);
    reset_n = 1'b1;
    step(1);

    // IR3 edge: int_req two cycles later, then the two-ack sequence.
    ir_in = 8'h08;
    step(1);
    chk("t1_irr", irr, 8'h08);
    chk("t1_int_early", int_req, 0);
    step(1);
    chk("t1_int_req", int_req, 1);
    pulse_ack();
    chk("t1_isr", isr, 8'h08);
    chk("t1_irr_clr", irr, 8'h00);
    chk("t1_int_drop", int_req, 0);
    exp_q.push_back(8'h43);
    pulse_ack();
    ir_in = 8'h00;
    write_ocw2(8'h63);
    chk("t1_speoi", isr, 8'h00);

    // IR2 in service blocks IR5 until a non-specific EOI.
    ir_in = 8'h04;
    wait_int("t2_int_ir2");
    full_ack(8'h42);
    ir_in = 8'h24;
    step(3);
    chk("t2_blocked", int_req, 0);
    chk("t2_irr", irr, 8'h20);
    write_ocw2(8'h20);
    chk("t2_nseoi", isr, 8'h00);
    step(1);
    chk("t2_int_ir5", int_req, 1);
    full_ack(8'h45);
    write_ocw2(8'h20);
    chk("t2_nseoi2", isr, 8'h00);
    ir_in = 8'h00;

    // Lowest priority 4: IR5 beats IR1.
    write_ocw2(8'hC4);
    ir_in = 8'h22;
    wait_int("t3_int");
    full_ack(8'h45);
    chk("t3_isr", isr, 8'h20);
    write_ocw2(8'h20);
    wait_int("t3_int_ir1");
    full_ack(8'h41);
    write_ocw2(8'h20);
    chk("t3_isr_clr", isr, 8'h00);
    ir_in = 8'h00;
    write_ocw2(8'hC7);

    // IR6 vanishes before the first ack: spurious vector 7.
    ir_in = 8'h40;
    step(2);
    chk("t4_int", int_req, 1);
    ir_in = 8'h00;
    step(1);
    chk("t4_irr_gone", irr, 8'h00);
    pulse_ack();
    chk("t4_isr_a", isr, 8'h00);
    exp_q.push_back(8'h47);
    pulse_ack();
    chk("t4_isr_b", isr, 8'h00);

    // AEOI with rotation: after IR0 served, IR1 has top priority.
    auto_eoi = 1'b1;
    write_ocw2(8'h80);
    ir_in = 8'h01;
    wait_int("t5_int");
    pulse_ack();
    chk("t5_isr_set", isr, 8'h01);
    exp_q.push_back(8'h40);
    pulse_ack();
    chk("t5_isr_aeoi", isr, 8'h00);
    ir_in = 8'h00;
    step(1);
    ir_in = 8'h03;
    wait_int("t5_int_ir1");
    pulse_ack();
    chk("t5_isr_ir1", isr, 8'h02);
    exp_q.push_back(8'h41);
    pulse_ack();
    wait_int("t5_int_ir0");
    full_ack(8'h40);
    chk("t5_isr_end", isr, 8'h00);
    auto_eoi = 1'b0;
    write_ocw2(8'h00);
    write_ocw2(8'hC7);
    ir_in = 8'h00;

    // Poll with and without a pending request.
    ir_in = 8'h10;
    wait_int("t6_int");
    exp_q.push_back(8'h84);
    pulse_poll();
    chk("t6_isr", isr, 8'h10);
    chk("t6_int_drop", int_req, 0);
    write_ocw2(8'h20);
    ir_in = 8'h00;
    exp_q.push_back(8'h00);
    pulse_poll();

    // Masking: a masked request raises nothing until unmasked.
    write_imr(8'h04);
    ir_in = 8'h04;
    step(3);
    chk("t7_imr", imr, 8'h04);
    chk("t7_masked", int_req, 0);
    chk("t7_irr", irr, 8'h04);
    write_imr(8'h00);
    wait_int("t7_int");
    full_ack(8'h42);
    write_ocw2(8'h20);
    ir_in = 8'h00;

    // init_clear during ACK1 aborts the sequence.
    write_imr(8'h01);
    ir_in = 8'h10;
    wait_int("t8_int");
    pulse_ack();
    chk("t8_isr", isr, 8'h10);
    init_clear = 1'b1;
    step(1);
    init_clear = 1'b0;
    chk("t8_isr_clr", isr, 8'h00);
    chk("t8_imr_clr", imr, 8'h00);
    chk("t8_irr_clr", irr, 8'h00);
    chk("t8_int", int_req, 0);
    pulse_ack();
    step(3);
    chk("t8_no_retrigger", int_req, 0);
    ir_in = 8'h00;

    // Level mode tracks ir_in and withdraws int_req when the line drops.
    level_trig = 1'b1;
    ir_in = 8'h02;
    step(1);
    chk("t9_irr", irr, 8'h02);
    step(1);
    chk("t9_int", int_req, 1);
    ir_in = 8'h00;
    step(1);
    chk("t9_irr_low", irr, 8'h00);
    step(1);
    chk("t9_int_drop", int_req, 0);
    level_trig = 1'b0;

    step(3);
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
